// File: rtl/avalon_sram_bridge_if.sv
// Avalon-MM slave-side bundle between a bus master and the SRAM bridge.
// master drives requests; slave answers with waitrequest/readdata/readdatavalid.
interface avalon_sram_bridge_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DW     = 32
) ();
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DW-1:0]     avs_writedata;
    logic [DW/8-1:0]   avs_byteenable;
    logic              avs_waitrequest;
    logic [DW-1:0]     avs_readdata;
    logic              avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/avalon_sram_bridge.sv
// Avalon-MM slave that drives a single-port SRAM macro with LC-cycle read latency.
// Partial byte-enable writes become read-modify-write; one transfer in flight at a time.
module avalon_sram_bridge #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DW     = 32,
    parameter int unsigned LC     = 1
) (
    input  logic                clk,
    input  logic                reset,
    avalon_sram_bridge_if.slave avs,
    output logic                sram_cs,
    output logic [3:0]          sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DW-1:0]       sram_wdata,
    input  logic [DW-1:0]       sram_rdata
);
    localparam int unsigned NB    = 4;
    localparam int unsigned CNT_W = 2;

    if (LC > 2 || DW != 32) begin : g_param_check
        $error("avalon_sram_bridge: LC must be 0, 1 or 2 and DW must be 32");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR      = 3'd2,
        RMW_RD  = 3'd3,
        RMW_WR  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cs_q, cs_d;
    logic [NB-1:0]      we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [NB-1:0]      be_q, be_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               rdv_q, rdv_d;
    logic [DW-1:0]      merged;

    // Byte merge for RMW: enabled lanes from the latched write data, others from the SRAM word.
    always_comb begin
        merged = sram_rdata;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        rdv_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Write wins over a simultaneous read; a zero-lane write is accepted as a no-op.
                if (avs.avs_write) begin
                    if (avs.avs_byteenable == 4'hF) begin
                        cs_d    = 1'b1;
                        we_d    = 4'hF;
                        addr_d  = avs.avs_address;
                        wdata_d = avs.avs_writedata;
                        state_d = WR;
                    end else if (avs.avs_byteenable != 4'h0) begin
                        cs_d    = 1'b1;
                        we_d    = 4'h0;
                        addr_d  = avs.avs_address;
                        wdata_d = avs.avs_writedata;
                        be_d    = avs.avs_byteenable;
                        cnt_d   = '0;
                        state_d = RMW_RD;
                    end
                end else if (avs.avs_read) begin
                    cs_d    = 1'b1;
                    we_d    = 4'h0;
                    addr_d  = avs.avs_address;
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT, RMW_RD: begin
                // cs stays high for LC edges so a pipelined SRAM keeps its read going.
                if (cnt_q == CNT_W'(LC)) begin
                    if (state_q == RD_WAIT) begin
                        rdata_d = sram_rdata;
                        rdv_d   = 1'b1;
                        cs_d    = 1'b0;
                        state_d = IDLE;
                    end else begin
                        we_d    = 4'hF;
                        wdata_d = merged;
                        state_d = RMW_WR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WR, RMW_WR: begin
                cs_d    = 1'b0;
                we_d    = 4'h0;
                state_d = IDLE;
            end

            default: begin
                cs_d    = 1'b0;
                we_d    = 4'h0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            rdv_q   <= rdv_d;
        end
    end

    assign avs.avs_waitrequest   = (state_q != IDLE) | reset;
    assign avs.avs_readdata      = rdata_q;
    assign avs.avs_readdatavalid = rdv_q;
    assign sram_cs               = cs_q;
    assign sram_we               = we_q;
    assign sram_addr             = addr_q;
    assign sram_wdata            = wdata_q;
endmodule

// File: tb/tb_avalon_sram_bridge.sv
// Bench for avalon_sram_bridge: three instances (LC = 0, 1, 2) each with an SRAM model,
// driven by directed and random transfers and checked against a word-array reference.
module tb_avalon_sram_bridge;
    localparam int unsigned AW = 5;
    localparam int OP_RD = 0;
    localparam int OP_WR = 1;
    localparam int OP_RW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Master-side stimulus per instance
    logic [AW-1:0] addr_a [3];
    logic          rd_a   [3];
    logic          wr_a   [3];
    logic [31:0]   wd_a   [3];
    logic [3:0]    be_a   [3];
    logic          rst_a  [3];

    wire           wait_w  [3];
    wire           rdv_w   [3];
    wire [31:0]    rdata_w [3];
    wire           cs_w    [3];
    wire [3:0]     we_w    [3];
    wire [AW-1:0]  saddr_w [3];
    wire [31:0]    swd_w   [3];

    // Reference: memory contents and read completions keyed by the cycle they must appear in.
    bit [31:0]   ref_mem  [3][32];
    logic [31:0] exp_data [3][8];
    bit          exp_vld  [3][8];
    int          last_n   [3];
    int          last_dur [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lc
        avalon_sram_bridge_if #(.ADDR_W(AW), .DW(32)) bus ();
        logic          cs;
        logic [3:0]    we;
        logic [AW-1:0] sa;
        logic [31:0]   swd;
        logic [31:0]   srd;
        bit   [31:0]   mem [32];
        logic [31:0]   p1, p2;

        assign bus.avs_address    = addr_a[g];
        assign bus.avs_read       = rd_a[g];
        assign bus.avs_write      = wr_a[g];
        assign bus.avs_writedata  = wd_a[g];
        assign bus.avs_byteenable = be_a[g];
        assign wait_w[g]  = bus.avs_waitrequest;
        assign rdv_w[g]   = bus.avs_readdatavalid;
        assign rdata_w[g] = bus.avs_readdata;
        assign cs_w[g]    = cs;
        assign we_w[g]    = we;
        assign saddr_w[g] = sa;
        assign swd_w[g]   = swd;

        avalon_sram_bridge #(.ADDR_W(AW), .DW(32), .LC(g)) dut (
            .clk        (clk),
            .reset      (rst_a[g]),
            .avs        (bus),
            .sram_cs    (cs),
            .sram_we    (we),
            .sram_addr  (sa),
            .sram_wdata (swd),
            .sram_rdata (srd)
        );

        // SRAM: any we bit writes the whole word; read data appears g clocks after the strobe.
        always @(posedge clk) begin
            if (cs && we != 4'h0) mem[sa] <= swd;
            p1 <= mem[sa];
            p2 <= p1;
        end
        assign srd = (g == 0) ? mem[sa] : (g == 1) ? p1 : p2;
    end

    // readdatavalid must pulse exactly in the cycles the model scheduled, with the model's data.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int s;
            s = cyc % 8;
            if (rdv_w[k] || exp_vld[k][s]) begin
                check($sformatf("lc%0d_rdv_timing", k), 32'(rdv_w[k]), 32'(exp_vld[k][s]));
                if (rdv_w[k] && exp_vld[k][s])
                    check($sformatf("lc%0d_readdata", k), rdata_w[k], exp_data[k][s]);
            end
            exp_vld[k][s] = 1'b0;
        end
    end

    // Present one transfer at a negedge, wait for acceptance, update the model; returns at the negedge after accept.
    task automatic do_op(input int k, input int kind, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] b, output int n);
        int tries;
        int dur;
        logic [31:0] m;
        addr_a[k] = a;
        wd_a[k]   = d;
        be_a[k]   = b;
        rd_a[k]   = (kind != OP_WR);
        wr_a[k]   = (kind != OP_RD);
        tries = 0;
        while (wait_w[k] && tries < 40) begin
            @(negedge clk);
            tries++;
        end
        if (wait_w[k]) check("accept_timeout", 32'(wait_w[k]), 32'd0);
        n = cyc;
        if (last_dur[k] != 0) check($sformatf("lc%0d_spacing", k), 32'(n - last_n[k]), 32'(last_dur[k]));

        if (kind == OP_RD) begin
            exp_data[k][(n + k + 2) % 8] = ref_mem[k][a];
            exp_vld[k][(n + k + 2) % 8]  = 1'b1;
            dur = k + 2;
        end else if (b == 4'hF) begin
            ref_mem[k][a] = d;
            dur = 2;
        end else if (b == 4'h0) begin
            dur = 1;
        end else begin
            m = ref_mem[k][a];
            for (int i = 0; i < 4; i++)
                if (b[i]) m[8*i +: 8] = d[8*i +: 8];
            ref_mem[k][a] = m;
            dur = k + 3;
        end

        @(posedge clk);
        @(negedge clk);
        rd_a[k] = 1'b0;
        wr_a[k] = 1'b0;

        if (kind != OP_RD && b == 4'h0) begin
            check("zero_be_cs", 32'(cs_w[k]), 32'd0);
            check("zero_be_wait", 32'(wait_w[k]), 32'd0);
        end else begin
            check("strobe_cs", 32'(cs_w[k]), 32'd1);
            check("strobe_addr", 32'(saddr_w[k]), 32'(a));
            check("strobe_we", 32'(we_w[k]), (kind != OP_RD && b == 4'hF) ? 32'hF : 32'h0);
            if (kind != OP_RD && b == 4'hF) check("strobe_wdata", swd_w[k], d);
        end
        last_n[k]   = n;
        last_dur[k] = dur;
    endtask

    task automatic reset_check(input int k);
        repeat (2) @(negedge clk);
        check("rst_wait", 32'(wait_w[k]), 32'd1);
        check("rst_rdv", 32'(rdv_w[k]), 32'd0);
        check("rst_rdata", rdata_w[k], 32'd0);
        check("rst_cs", 32'(cs_w[k]), 32'd0);
        check("rst_we", 32'(we_w[k]), 32'd0);
        check("rst_addr", 32'(saddr_w[k]), 32'd0);
        check("rst_wdata", swd_w[k], 32'd0);
        rst_a[k] = 1'b0;
        @(negedge clk);
        check("post_rst_wait", 32'(wait_w[k]), 32'd0);
    endtask

    // Reset lands while the read is outstanding: no pulse, strobes drop, next read works.
    task automatic reset_mid_read(input int k);
        int n;
        do_op(k, OP_RD, 5'd5, 32'd0, 4'h0, n);
        exp_vld[k][(n + k + 2) % 8] = 1'b0;
        rst_a[k] = 1'b1;
        #1;
        check("midrst_cs", 32'(cs_w[k]), 32'd0);
        check("midrst_wait", 32'(wait_w[k]), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("midrst_hold_wait", 32'(wait_w[k]), 32'd1);
        end
        rst_a[k]    = 1'b0;
        last_dur[k] = 0;
        @(negedge clk);
        check("midrst_release_wait", 32'(wait_w[k]), 32'd0);
        do_op(k, OP_RD, 5'd3, 32'd0, 4'h0, n);
    endtask

    task automatic run_lc(input int k);
        int n;
        int r;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    b;
        reset_check(k);
        do_op(k, OP_WR, 5'd3, 32'hDEADBEEF, 4'hF, n);
        do_op(k, OP_RD, 5'd3, 32'd0, 4'h0, n);
        do_op(k, OP_RD, 5'd0, 32'd0, 4'h0, n);
        do_op(k, OP_RD, 5'd1, 32'd0, 4'h0, n);
        do_op(k, OP_WR, 5'd7, 32'h11223344, 4'hF, n);
        do_op(k, OP_WR, 5'd7, 32'hAABBCCDD, 4'b0101, n);
        do_op(k, OP_RD, 5'd7, 32'd0, 4'h0, n);
        do_op(k, OP_WR, 5'd2, 32'h5A5A5A5A, 4'hF, n);
        do_op(k, OP_WR, 5'd2, 32'hFFFFFFFF, 4'h0, n);
        do_op(k, OP_RD, 5'd2, 32'd0, 4'h0, n);
        do_op(k, OP_RW, 5'd4, 32'h00000001, 4'hF, n);
        do_op(k, OP_RD, 5'd4, 32'd0, 4'h0, n);
        reset_mid_read(k);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            d = $urandom;
            b = 4'($urandom_range(1, 14));
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                last_dur[k] = 0;
            end
            if (r < 4)       do_op(k, OP_RD, a, d, 4'h0, n);
            else if (r < 6)  do_op(k, OP_WR, a, d, 4'hF, n);
            else if (r < 8)  do_op(k, OP_WR, a, d, b, n);
            else if (r == 8) do_op(k, OP_WR, a, d, 4'h0, n);
            else             do_op(k, OP_RW, a, d, ($urandom_range(0, 1) == 1) ? 4'hF : b, n);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_a[k]    = 1'b1;
            rd_a[k]     = 1'b0;
            wr_a[k]     = 1'b0;
            addr_a[k]   = '0;
            wd_a[k]     = '0;
            be_a[k]     = '0;
            last_n[k]   = 0;
            last_dur[k] = 0;
        end
        fork
            run_lc(0);
            run_lc(1);
            run_lc(2);
        join
        repeat (8) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
